// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the pipelined ALU and the decode stage.
//   - ALU_OP_W     : opcode width
//   - alu_op_e     : opcode encodings
//   - alu_state_e  : output-stage FSM states
//   - alu_flags_t  : registered flag bundle (MSB first: N, Z, V, C)
//   - is_mul_op()  : true when the opcode selects the iterative multiplier
// ----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_PASS_B = 4'b0000,
    OP_ADD    = 4'b0010,
    OP_SUB    = 4'b0011,
    OP_AND    = 4'b0100,
    OP_OR     = 4'b0101,
    OP_XOR    = 4'b0110,
    OP_LSL    = 4'b1000,
    OP_LSR    = 4'b1001,
    OP_MUL    = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic negative;
    logic zero;
    logic overflow;
    logic carry_out;
  } alu_flags_t;

  // With the multiplier compiled out, MUL decodes as an illegal op.
  function automatic logic is_mul_op(input logic [ALU_OP_W-1:0] op, input logic mul_en);
    return mul_en && (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// ----------------------------------------------------------------------------
// alu_mul_iter
//   Shift-add multiplier, one multiplier bit per cycle, WIDTH cycles.
//   Keeps only the low WIDTH bits of the product.
//   Ports:
//     clk, reset      : clock, async active-high reset
//     start           : load a/b, clear accumulator, begin iterating
//     a, b            : multiplicand / multiplier (sampled on start)
//     done            : one-cycle pulse once all WIDTH bits are consumed
//     product         : accumulator (valid while done is high)
// ----------------------------------------------------------------------------
module alu_mul_iter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == CNT_LAST) begin
        // done has been presented for this cycle; retire.
        active_d = 1'b0;
      end else begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign done    = active_q && (cnt_q == CNT_LAST);
  assign product = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// ----------------------------------------------------------------------------
// alu_pipe
//   Registered, valid/ready ALU. Single-cycle ops appear one cycle after
//   accept; MUL runs through alu_mul_iter and appears WIDTH+1 cycles later.
//   Ports:
//     clk, reset                 : clock, async active-high reset
//     in_valid / in_ready        : operand handshake
//     op, a, b                   : opcode and operands
//     out_valid / out_ready      : result handshake
//     result                     : registered result
//     negative, zero, overflow, carry_out : registered flags
// ----------------------------------------------------------------------------
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    result,
  output logic                negative,
  output logic                zero,
  output logic                overflow,
  output logic                carry_out
);

  localparam int SH_W = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;

  logic             mul_op, accept, mul_start, mul_done;
  logic [WIDTH-1:0] mul_prod;

  // -------------------------------------------------------------------------
  // Combinational single-cycle datapath
  // -------------------------------------------------------------------------
  logic             is_sub, arith;
  logic [WIDTH-1:0] b_op, alu_res;
  logic [WIDTH:0]   sum;
  alu_flags_t       alu_flg, mul_flg;

  always_comb begin
    is_sub  = (op == OP_SUB);
    // SUB is a + ~b + 1, so add/sub share one WIDTH+1 adder.
    b_op    = is_sub ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
    alu_res = '0;
    arith   = 1'b0;
    case (op)
      OP_PASS_B:      alu_res = b;
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        arith   = 1'b1;
      end
      OP_AND:         alu_res = a & b;
      OP_OR:          alu_res = a | b;
      OP_XOR:         alu_res = a ^ b;
      OP_LSL:         alu_res = a << b[SH_W-1:0];
      OP_LSR:         alu_res = a >> b[SH_W-1:0];
      default:        alu_res = '0;  // illegal; MUL takes the iterative path
    endcase
    alu_flg.negative  = alu_res[WIDTH-1];
    alu_flg.zero      = (alu_res == '0);
    alu_flg.carry_out = arith & sum[WIDTH];
    // Signed overflow: operands (after inversion for SUB) agree in sign and
    // the result sign differs from them.
    alu_flg.overflow  = arith & (a[WIDTH-1] == b_op[WIDTH-1]) &
                        (alu_res[WIDTH-1] != a[WIDTH-1]);

    mul_flg.negative  = mul_prod[WIDTH-1];
    mul_flg.zero      = (mul_prod == '0);
    mul_flg.overflow  = 1'b0;
    mul_flg.carry_out = 1'b0;
  end

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  // in_ready depends only on state and out_ready, so HOLD can drain and
  // reload on the same edge without a combinational path from in_valid.
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
  assign out_valid = (state_q == ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign mul_op    = is_mul_op(op, MUL_EN);
  assign mul_start = accept && mul_op;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );

  // -------------------------------------------------------------------------
  // FSM + output register
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          if (mul_op) begin
            state_d = ST_BUSY;
          end else begin
            state_d  = ST_HOLD;
            result_d = alu_res;
            flags_d  = alu_flg;
          end
        end else if (state_q == ST_HOLD && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mul_done) begin
          state_d  = ST_HOLD;
          result_d = mul_prod;
          flags_d  = mul_flg;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign result = result_q;
  assign {negative, zero, overflow, carry_out} = flags_q;

endmodule
